// File: rtl/cpu_datapath_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : shared definitions for the control-ROM execution datapath.
//   - ALU operation codes (ALU_ADD .. ALU_OP7)
//   - Bit positions of the flags inside the 4-bit NZVC vector
//   - Default data / address widths
// Optional feature macro CPU_DATAPATH_ADC_EN changes the meaning of ALU_OP6 and
// ALU_OP7 (see cpu_alu); the codes themselves do not change.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_DATA_W = 4;
    localparam int CPU_ADDR_W = 8;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'd0;
    localparam alu_op_t ALU_SUB = 3'd1;
    localparam alu_op_t ALU_AND = 3'd2;
    localparam alu_op_t ALU_OR  = 3'd3;
    localparam alu_op_t ALU_XOR = 3'd4;
    localparam alu_op_t ALU_NOT = 3'd5;
    localparam alu_op_t ALU_OP6 = 3'd6;  // pass B, or ADC with CPU_DATAPATH_ADC_EN
    localparam alu_op_t ALU_OP7 = 3'd7;  // zero,   or SBC with CPU_DATAPATH_ADC_EN

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/cpu_datapath_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_datapath_seq_if : control word, RAM bus and architectural outputs of the
// execution datapath, bundled into one interface.
//   master : drives the control word (run, ALUop, PCincr, Aload, Bload, Asel,
//            RAMwrite, imm, jump_addr) and RAM read data (ram_rdata);
//            observes PC, NZVC, A, ram_addr, ram_wdata, ram_we, halted.
//   slave  : the datapath itself (directions reversed).
// -----------------------------------------------------------------------------
interface cpu_datapath_seq_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8
);
    logic              run;
    logic [2:0]        ALUop;
    logic              PCincr;
    logic              Aload;
    logic              Bload;
    logic              Asel;
    logic              RAMwrite;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] jump_addr;
    logic [DATA_W-1:0] ram_rdata;

    logic [ADDR_W-1:0] PC;
    logic [3:0]        NZVC;
    logic [DATA_W-1:0] A;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              halted;

    modport master (
        output run, ALUop, PCincr, Aload, Bload, Asel, RAMwrite, imm, jump_addr, ram_rdata,
        input  PC, NZVC, A, ram_addr, ram_wdata, ram_we, halted
    );

    modport slave (
        input  run, ALUop, PCincr, Aload, Bload, Asel, RAMwrite, imm, jump_addr, ram_rdata,
        output PC, NZVC, A, ram_addr, ram_wdata, ram_we, halted
    );
endinterface

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu : purely combinational ALU for the execution datapath.
// Ports:
//   i_a, i_b   operands (DATA_W)
//   i_op       operation code (cpu_pkg ALU_*)
//   i_cin      current C flag (only consumed by ADC/SBC)
//   o_result   result truncated to DATA_W
//   o_n/o_z/o_v/o_c  flags for the result
// Macro CPU_DATAPATH_ADC_EN: op 6 = ADC (A+B+C), op 7 = SBC (A-B-~C).
// Without it: op 6 = pass B, op 7 = zero.
// -----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_t           i_op,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_result,
    output logic              o_n,
    output logic              o_z,
    output logic              o_v,
    output logic              o_c
);
    // Every arithmetic op is one adder: A + (B or ~B) + carry_in.
    // Subtraction uses ~B with carry_in=1, so carry out means "no borrow".
    logic              w_is_arith;
    logic              w_is_sub;
    logic              w_carry_in;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_sum;

`ifndef CPU_DATAPATH_ADC_EN
    logic w_unused_cin;
    assign w_unused_cin = i_cin;
`endif

    always_comb begin
        w_is_arith = 1'b0;
        w_is_sub   = 1'b0;
        w_carry_in = 1'b0;
        case (i_op)
            ALU_ADD: begin w_is_arith = 1'b1; end
            ALU_SUB: begin w_is_arith = 1'b1; w_is_sub = 1'b1; w_carry_in = 1'b1; end
`ifdef CPU_DATAPATH_ADC_EN
            ALU_OP6: begin w_is_arith = 1'b1; w_carry_in = i_cin; end
            // A - B - ~C == A + ~B + C
            ALU_OP7: begin w_is_arith = 1'b1; w_is_sub = 1'b1; w_carry_in = i_cin; end
`endif
            default: ;
        endcase

        w_b_eff = w_is_sub ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_carry_in};

        o_result = '0;
        o_v      = 1'b0;
        o_c      = 1'b0;
        if (w_is_arith) begin
            o_result = w_sum[DATA_W-1:0];
            o_c      = w_sum[DATA_W];
            // Signed overflow: operands of equal sign giving a result of the other sign.
            o_v      = (i_a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != i_a[DATA_W-1]);
        end else begin
            case (i_op)
                ALU_AND: o_result = i_a & i_b;
                ALU_OR:  o_result = i_a | i_b;
                ALU_XOR: o_result = i_a ^ i_b;
                ALU_NOT: o_result = ~i_a;
                ALU_OP6: o_result = i_b;
                default: o_result = '0;
            endcase
        end

        o_n = o_result[DATA_W-1];
        o_z = (o_result == '0);
    end
endmodule

// File: rtl/cpu_datapath_seq.sv
// -----------------------------------------------------------------------------
// cpu_datapath_seq : execution end of the control-ROM CPU. Consumes one control
// word per clock and holds the architectural state A, B, PC, NZVC and halted.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-low reset
//   bus     cpu_datapath_seq_if.slave (control word in, RAM bus and state out)
// A clock edge with run=1 and halted=0 is a step; otherwise nothing changes.
// A step that jumps to its own PC executes once and then sets the sticky halt.
// Macro CPU_DATAPATH_ADC_EN (in cpu_alu) turns ALU ops 6/7 into ADC/SBC.
// -----------------------------------------------------------------------------
module cpu_datapath_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    cpu_datapath_seq_if.slave  bus
);
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_nzvc;
    logic              r_halted;

    logic              w_step;
    logic              w_halt_hit;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] w_a_next;
    logic [3:0]        w_flags_next;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_n;
    logic              w_alu_z;
    logic              w_alu_v;
    logic              w_alu_c;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (bus.ALUop),
        .i_cin    (r_nzvc[FLAG_C]),
        .o_result (w_alu_result),
        .o_n      (w_alu_n),
        .o_z      (w_alu_z),
        .o_v      (w_alu_v),
        .o_c      (w_alu_c)
    );

    always_comb begin
        w_step     = bus.run & ~r_halted;
        w_pc_next  = bus.PCincr ? (r_pc + ADDR_W'(1)) : bus.jump_addr;
        w_halt_hit = w_step & ~bus.PCincr & (bus.jump_addr == r_pc);

        w_a_next     = w_alu_result;
        w_flags_next = '0;
        if (bus.Asel) begin
            // Loading from RAM: N/Z describe the loaded value, V/C are cleared.
            w_a_next             = bus.ram_rdata;
            w_flags_next[FLAG_N] = bus.ram_rdata[DATA_W-1];
            w_flags_next[FLAG_Z] = (bus.ram_rdata == '0);
        end else begin
            w_flags_next[FLAG_N] = w_alu_n;
            w_flags_next[FLAG_Z] = w_alu_z;
            w_flags_next[FLAG_V] = w_alu_v;
            w_flags_next[FLAG_C] = w_alu_c;
        end
    end

    // Aload and Bload in the same step both see pre-edge A/B, since the ALU
    // reads the registers and B only updates at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_nzvc   <= '0;
            r_halted <= 1'b0;
        end else if (w_step) begin
            r_pc <= w_pc_next;
            if (bus.Aload) begin
                r_a    <= w_a_next;
                r_nzvc <= w_flags_next;
            end
            if (bus.Bload) begin
                r_b <= bus.imm;
            end
            if (w_halt_hit) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.PC        = r_pc;
    assign bus.NZVC      = r_nzvc;
    assign bus.A         = r_a;
    assign bus.ram_addr  = bus.jump_addr;
    assign bus.ram_wdata = r_a;
    assign bus.ram_we    = bus.RAMwrite & w_step;
    assign bus.halted    = r_halted;
endmodule

// File: doc/cpu_datapath_seq.md
Name: cpu_datapath_seq

Overview:
Execution end of the control ROM interface. The control ROM maps {PC, NZVC} to a control word (ALUop, PCincr, Aload, Bload, Asel, RAMwrite). This block consumes that word each clock and holds the architectural state: A, B, PC and the NZVC flags register. It also executes the ALU operation and drives data RAM. Its PC and NZVC outputs feed back as the ROM address, closing the fetch/execute loop.

Parameters:
DATA_W, 4, width of A, B, ALU and RAM data
ADDR_W, 8, width of PC and RAM/jump address

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = execute one control word per clock; 0 = hold all state
ALUop  in  3  ALU operation select
PCincr  in  1  1 = PC+1; 0 = PC loads jump_addr
Aload  in  1  load A and update flags
Bload  in  1  load B from imm
Asel  in  1  A source: 0 = ALU result, 1 = ram_rdata
RAMwrite  in  1  request RAM write of A
imm  in  DATA_W  instruction immediate operand
jump_addr  in  ADDR_W  instruction address operand; also RAM address
ram_rdata  in  DATA_W  RAM read data (combinational RAM)
PC  out  ADDR_W  program counter, registered
NZVC  out  4  flags {N,Z,V,C}, registered
A  out  DATA_W  A register
ram_addr  out  ADDR_W  equals jump_addr
ram_wdata  out  DATA_W  equals A
ram_we  out  1  RAMwrite & run & ~halted
halted  out  1  sticky halt indicator

Behaviour:
- Reset (reset=0, asynchronous): PC=0, A=0, B=0, NZVC=0000, halted=0. Reset mid-cycle discards the in-flight control word.
- Step: a clock edge with run=1 and halted=0 is a step. Without a step, no register changes and ram_we=0.
- Latency: one clock per control word. Registers are visible the cycle after the edge.
- ALU: combinational on current A, B.
  - 0 ADD = A+B
  - 1 SUB = A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 pass B
  - 7 zero
- Result width: the result is truncated to DATA_W bits.
- Flags:
  - N = result MSB; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 when no borrow (A>=B unsigned); V = signed overflow.
  - Other ops: V=0, C=0.
- Aload on step: A <= (Asel ? ram_rdata : ALU result).
  - NZVC <= ALU flags when Asel=0.
  - When Asel=1: N and Z are computed from ram_rdata; V and C are cleared.
- Bload on step: B <= imm.
- Aload and Bload together: both load from the pre-edge values, so the ALU uses the old B.
- PC on step: PCincr=1 gives PC+1, wrapping 2^ADDR_W-1 to 0. PCincr=0 gives PC <= jump_addr.
- Halt detect: a step with PCincr=0 and jump_addr==PC sets halted=1.
  - PC still loads (unchanged), so the self-jump word executes its Aload/Bload/RAMwrite once.
  - After that, halted freezes all state until reset.
- RAM: ram_we is combinational; the write takes effect at the RAM on the same clock edge.

Optional Feature:
CPU_DATAPATH_ADC_EN
- Defined: ALUop 6 = ADC (A+B+C_flag), ALUop 7 = SBC (A-B-~C_flag). Flags for these ops follow the ADD/SUB rules.
- Undefined: ALUop 6 = pass B, ALUop 7 = zero, as listed above.

Decomposition:
- Shared package cpu_pkg:
  - ALUop localparams (ALU_ADD .. ALU_OP7)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0)
  - default DATA_W/ADDR_W
- One sub-module: cpu_alu, purely combinational. Inputs: A, B, op, cin. Outputs: result, N, Z, V, C.
- cpu_datapath_seq holds all registers and the halt logic.

Test Plan:
1. Reset: assert reset=0 mid-run with PC=0x23 -> PC=0x00, A=0, NZVC=0000, halted=0 immediately, without waiting for a clock edge.
2. Bload imm=3, then Aload ADD Asel=0 with A=0 -> A=3, NZVC=0000; PC steps 0x00->0x01->0x02. A step with run=0 leaves PC=0x02.
3. A=7, B=1, ADD -> A=8, NZVC=1010. A=3, B=3, SUB -> A=0, NZVC=0101.
4. PC=0xFF, PCincr=1 -> PC=0x00. PCincr=0, jump_addr=0x40 -> PC=0x40.
5. At PC=0x40, PCincr=0, jump_addr=0x40, RAMwrite=1, A=5 -> one write of 5 to 0x40, halted=1. Subsequent RAMwrite/Aload have no effect and ram_we stays 0.
6. With CPU_DATAPATH_ADC_EN: C=1, A=2, B=3, ALUop=6 -> A=6. Without the macro, the same stimulus -> A=3 (pass B).
